// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: upstream sequencer for the 8:1 byte mux.
// It walks the enabled channels in ascending order, drives the mux select,
// captures each selected byte and offers it on a valid/ready stream tagged
// with its channel number. Scanning is either a single pass or a continuous
// round-robin.
// Optional build macro: MUX_SCAN_PARITY_EN adds out_par, the XOR-reduce of
// the captured byte.
module mux_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [NCH-1:0]   ch_en,
  output logic [SELW-1:0]  sel,
  input  logic [WIDTH-1:0] mux_y,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_ch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
`ifdef MUX_SCAN_PARITY_EN
  output logic             out_par,
`endif
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t           state_q;
  logic [NCH-1:0]   mask_q;
  logic [SELW-1:0]  sel_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
`ifdef MUX_SCAN_PARITY_EN
  logic             par_q;
`endif

  // Search results for the next channel to visit.
  logic [SELW-1:0]  low_sel_d;
  logic             low_any_d;
  logic [SELW-1:0]  nxt_sel_d;
  logic             nxt_any_d;

  // Lowest enabled channel in the live mask (used at start and at wrap).
  always_comb begin
    low_sel_d = '0;
    low_any_d = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_en[i] && !low_any_d) begin
        low_sel_d = SELW'(i);
        low_any_d = 1'b1;
      end
    end
  end

  // Next enabled channel above the current one in the snapshot mask.
  always_comb begin
    nxt_sel_d = '0;
    nxt_any_d = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (mask_q[i] && (SELW'(i) > sel_q) && !nxt_any_d) begin
        nxt_sel_d = SELW'(i);
        nxt_any_d = 1'b1;
      end
    end
  end

  // Scan FSM with all outputs held in registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (low_any_d) begin
              mask_q  <= ch_en;
              sel_q   <= low_sel_d;
              busy_q  <= 1'b1;
              state_q <= S_DRIVE;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        S_DRIVE: begin
          data_q  <= mux_y;
`ifdef MUX_SCAN_PARITY_EN
          par_q   <= ^mux_y;
`endif
          valid_q <= 1'b1;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            // Wrap reloads from the live ch_en; an empty reload ends the scan.
            if (nxt_any_d) begin
              sel_q   <= nxt_sel_d;
              state_q <= S_DRIVE;
            end else if (cont && low_any_d) begin
              mask_q  <= ch_en;
              sel_q   <= low_sel_d;
              state_q <= S_DRIVE;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign out_ch    = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef MUX_SCAN_PARITY_EN
  assign out_par   = par_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed bench for mux_scan_ctrl. The mux is modelled as
// input n carrying 8'h10+n.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cont;
  logic [7:0] ch_en;
  logic [2:0] sel;
  logic [7:0] mux_y;
  logic [7:0] out_data;
  logic [2:0] out_ch;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
`ifdef MUX_SCAN_PARITY_EN
  logic       out_par;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mux_y = 8'h10 + {5'b0, sel};

  mux_scan_ctrl #(.WIDTH(8), .NCH(8), .SELW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cont      (cont),
    .ch_en     (ch_en),
    .sel       (sel),
    .mux_y     (mux_y),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef MUX_SCAN_PARITY_EN
    .out_par   (out_par),
`endif
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A presented sample from channel ch.
  task automatic chk_sample(input string tag, input logic [2:0] ch);
    logic [7:0] d;
    d = 8'h10 + {5'b0, ch};
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".ch"},    {29'b0, out_ch},    {29'b0, ch});
    chk({tag, ".data"},  {24'b0, out_data},  {24'b0, d});
    chk({tag, ".done"},  {31'b0, done},      32'd0);
`ifdef MUX_SCAN_PARITY_EN
    chk({tag, ".par"},   {31'b0, out_par},   {31'b0, ^d});
`endif
  endtask

  initial begin
    logic [2:0] seq [4];
    seq[0] = 3'd0; seq[1] = 3'd2; seq[2] = 3'd5; seq[3] = 3'd7;

    rst = 1'b1; start = 1'b0; cont = 1'b0; ch_en = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst.valid", {31'b0, out_valid}, 32'd0);
    chk("rst.busy",  {31'b0, busy},      32'd0);
    chk("rst.sel",   {29'b0, sel},       32'd0);
    chk("rst.data",  {24'b0, out_data},  32'd0);
    chk("rst.done",  {31'b0, done},      32'd0);

    // Single pass over channels 0,2,5,7 with a ready consumer.
    ch_en = 8'b1010_0101; cont = 1'b0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("sp.busy",  {31'b0, busy},      32'd1);
    chk("sp.sel0",  {29'b0, sel},       32'd0);
    chk("sp.lat1",  {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_sample("sp", seq[i]);
      tick();
      chk("sp.gap", {31'b0, out_valid}, 32'd0);
      if (i == 3) begin
        chk("sp.done", {31'b0, done}, 32'd1);
        chk("sp.idle", {31'b0, busy}, 32'd0);
      end else begin
        chk("sp.nsel", {29'b0, sel}, {29'b0, seq[i+1]});
      end
    end
    tick();
    chk("sp.done1", {31'b0, done}, 32'd0);

    // Backpressure on a single channel; a start while busy is ignored.
    ch_en = 8'h01; out_ready = 1'b0; start = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk_sample("bp", 3'd0);
      tick();
    end
    start = 1'b0;
    chk_sample("bp.last", 3'd0);
    out_ready = 1'b1;
    tick();
    chk("bp.done",  {31'b0, done},      32'd1);
    chk("bp.valid", {31'b0, out_valid}, 32'd0);
    chk("bp.busy",  {31'b0, busy},      32'd0);
    tick();
    chk("bp.done1", {31'b0, done},      32'd0);
    chk("bp.noxfr", {31'b0, out_valid}, 32'd0);

    // Empty mask.
    ch_en = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("em.done",  {31'b0, done},      32'd1);
    chk("em.busy",  {31'b0, busy},      32'd0);
    chk("em.valid", {31'b0, out_valid}, 32'd0);
    tick();
    chk("em.done1", {31'b0, done},      32'd0);
    chk("em.busy1", {31'b0, busy},      32'd0);

    // Continuous scan; ch_en change takes effect only at the wrap.
    ch_en = 8'b1000_0010; cont = 1'b1; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; ch_en = 8'h08;
    tick(); chk_sample("cw.a", 3'd1);
    tick(); chk("cw.gap1", {31'b0, out_valid}, 32'd0);
    tick(); chk_sample("cw.b", 3'd7);
    tick(); chk("cw.wrap", {29'b0, sel}, 32'd3);
            chk("cw.busy", {31'b0, busy}, 32'd1);
            chk("cw.nodn", {31'b0, done}, 32'd0);
    tick(); chk_sample("cw.c", 3'd3);
    tick(); chk("cw.rep", {29'b0, sel}, 32'd3);
    tick(); chk_sample("cw.d", 3'd3);
    cont = 1'b0;
    tick();
    chk("cw.done",  {31'b0, done},      32'd1);
    chk("cw.valid", {31'b0, out_valid}, 32'd0);
    chk("cw.busy0", {31'b0, busy},      32'd0);

    // Reset while a sample is being offered.
    ch_en = 8'h40; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_sample("mr.pre", 3'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr.valid", {31'b0, out_valid}, 32'd0);
    chk("mr.busy",  {31'b0, busy},      32'd0);
    chk("mr.sel",   {29'b0, sel},       32'd0);
    chk("mr.data",  {24'b0, out_data},  32'd0);
    chk("mr.ch",    {29'b0, out_ch},    32'd0);
    tick(); tick();
    chk("mr.stay",  {31'b0, out_valid}, 32'd0);
    chk("mr.busy1", {31'b0, busy},      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Upstream sequencer for the 8:1 byte mux. It drives the mux select and scans the enabled input channels in ascending order. For each channel it captures the selected byte and presents it on a valid/ready output stream, tagged with the channel number. It supports a single pass or continuous round-robin scanning.

Parameters:
WIDTH, 8, data width of each mux input and of mux_y/out_data
NCH, 8, number of mux channels (fixed at 8 in this revision)
SELW, 3, select width, equal to log2(NCH)

Ports:
clk  input  1  rising-edge clock; only clock in block
rst  input  1  synchronous reset, active-high
start  input  1  begin a scan; sampled only in IDLE
cont  input  1  1 = continuous scan (wrap), 0 = single pass; sampled at each wrap point
ch_en  input  NCH  channel enable mask; bit n enables mux input n
sel  output  SELW  select to mux
mux_y  input  WIDTH  mux output, combinational from sel
out_data  output  WIDTH  captured sample
out_ch  output  SELW  channel that out_data came from
out_valid  output  1  out_data/out_ch valid
out_ready  input  1  consumer accepts when high with out_valid
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at scan end

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-scan):
  - state=IDLE
  - sel=0, out_data=0, out_ch=0, out_valid=0, busy=0, done=0
  - mask snapshot=0
  - An in-flight sample is discarded.
- States: IDLE, DRIVE, OUT.
- IDLE:
  - start=1 with ch_en!=0: snapshot ch_en into mask; sel and out_ch <= lowest set bit; go to DRIVE.
  - start=1 with ch_en==0: done=1 for one cycle; stay in IDLE.
  - start=0: hold all outputs.
- DRIVE: settle cycle with sel stable. At the next edge: out_data<=mux_y, out_valid<=1, go to OUT.
- OUT:
  - out_valid, out_data and out_ch are held stable until out_ready=1. No drop, no overwrite.
  - On handshake, if a higher enabled bit exists in mask: sel and out_ch <= next higher enabled index, out_valid<=0, go to DRIVE.
  - On handshake at the last enabled channel with cont=1: reload mask from the current ch_en.
    - Nonzero: sel <= lowest set bit (wrap 7->0 region), go to DRIVE.
    - Zero: treat as scan end.
  - On handshake at the last enabled channel with cont=0: out_valid<=0, done=1 for one cycle, go to IDLE.
- Latency:
  - start high in cycle k -> sel valid in cycle k+1 -> out_valid high in cycle k+2.
  - Handshake in cycle m -> out_valid low in m+1 -> out_valid high in m+2.
  - Peak throughput: one sample per 2 cycles.
- ch_en changes mid-pass are ignored until the next start or wrap.
- start while busy is ignored.
- cont has effect only at the wrap point.
- done and out_valid are never high in the same cycle.
- Single enabled channel with cont=1: the same channel repeats each wrap.
- All outputs are registered. No combinational path from out_ready or mux_y to any output.

Optional Feature:
MUX_SCAN_PARITY_EN
- Defined: adds output out_par (1 bit) = even parity (XOR-reduce) of mux_y, captured in the same edge as out_data. It is held with out_data, resets to 0, and tracks out_data exactly.
- Undefined: port out_par and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset mid-scan: rst=1 while in OUT with out_valid=1 -> next cycle out_valid=0, busy=0, sel=0, out_data=0, state IDLE.
- Single pass:
  - Stimulus: ch_en=8'b1010_0101, cont=0, out_ready=1, mux inputs i_n=8'h10+n.
  - Required: out_ch sequence 0,2,5,7 with out_data 8'h10, 8'h12, 8'h15, 8'h17; done pulse after channel 7; busy=0 afterwards.
- Backpressure:
  - Stimulus: ch_en=8'h01, out_ready=0 for 5 cycles, then 1.
  - Required: out_valid and out_data=8'h10 held stable all 5 cycles; exactly one transfer; then done.
- Empty mask: start with ch_en=0 -> done=1 for one cycle, busy never asserts, out_valid never asserts.
- Continuous wrap:
  - Stimulus: ch_en=8'b1000_0010, cont=1; change ch_en to 8'h08 during the first pass.
  - Required: sequence 1,7,3,3,...; deassert cont -> ends after the current pass with done.
- Latency:
  - start in cycle k -> out_valid rises in cycle k+2.
  - With out_ready=1 constant -> out_valid toggles 1,0,1,0...
  - MUX_SCAN_PARITY_EN build: out_par=1 for data 8'h07.
